// File: rtl/edge_detect_pkg.sv
// -----------------------------------------------------------------------------
// edge_detect_pkg
//
// Shared types and helpers for the multi-channel edge detector.
//   edge_mode_t     : per-channel edge qualification mode.
//   cnt_width()     : width of a counter that must hold values 0..n-1 with
//                     one bit of headroom.
//   edge_qualifies(): decides whether an accepted transition to new_level
//                     is reported under a given mode.
// -----------------------------------------------------------------------------
package edge_detect_pkg;

  typedef enum logic [1:0] {
    EM_ANY  = 2'b00,  // report both directions
    EM_RISE = 2'b01,  // report 0 -> 1 only
    EM_FALL = 2'b10,  // report 1 -> 0 only
    EM_OFF  = 2'b11   // never report; the level is still tracked
  } edge_mode_t;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic logic edge_qualifies(input edge_mode_t m, input logic new_level);
    case (m)
      EM_ANY:  return 1'b1;
      EM_RISE: return new_level;
      EM_FALL: return ~new_level;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_detect_ch.sv
// -----------------------------------------------------------------------------
// edge_detect_ch
//
// One independent channel of the edge detector:
//   synchroniser -> debounce filter -> edge qualification -> pulse stretch,
//   plus a sticky event flag.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous, active-high reset
//   a          in   raw asynchronous input
//   mode       in   edge qualification mode for this channel
//   clr        in   one-cycle strobe clearing the sticky flag
//   pulse      out  registered, stretched event pulse
//   pulse_next out  next-state value of pulse (used by the top for 'any')
//   sticky     out  latched event flag
// -----------------------------------------------------------------------------
module edge_detect_ch
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int STRETCH       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  edge_mode_t mode,
  input  logic       clr,
  output logic       pulse,
  output logic       pulse_next,
  output logic       sticky
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam int SW = cnt_width(STRETCH);

  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STR_LOAD = SW'(STRETCH - 1);

  // Synchroniser chain; bit 0 is the first (metastability-exposed) flop.
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;

  // Debounce state: accepted stable level and the persistence counter.
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          event_hit;

  // Stretch state.
  logic [SW-1:0] str_q, str_d;
  logic          pulse_q, pulse_d;

  logic          sticky_q, sticky_d;

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every signal assigned in always_comb gets a default at the top so
  // that no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], a};

    level_d = level_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;

    if (s == level_q) begin
      // Any return to the stable level restarts the filter.
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // The new level has persisted for STABLE_CYCLES samples.
      level_d = s;
      cnt_d   = '0;
      accept  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // The new level equals s on an accepted transition.
    event_hit = accept && edge_qualifies(mode, s);

    str_d   = str_q;
    pulse_d = 1'b0;
    if (event_hit) begin
      // A fresh event reloads the counter, so a retrigger extends the pulse
      // without a low gap.
      pulse_d = 1'b1;
      str_d   = STR_LOAD;
    end else if (str_q != '0) begin
      pulse_d = 1'b1;
      str_d   = str_q - 1'b1;
    end

    // Set has priority over clear when both land in the same cycle.
    sticky_d = event_hit | (sticky_q & ~clr);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the synchroniser and stable level are loaded from the live input
      // rather than a constant, so the level present at reset release is
      // already "stable" and produces no event.
      sync_q   <= {SYNC_STAGES{a}};
      level_q  <= a;
      cnt_q    <= '0;
      str_q    <= '0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      str_q    <= str_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
    end
  end

  assign pulse      = pulse_q;
  assign pulse_next = pulse_d;
  assign sticky     = sticky_q;

endmodule

// File: rtl/edge_detect_n.sv
// -----------------------------------------------------------------------------
// edge_detect_n
//
// Multi-channel synchronised, debounced, mode-qualified edge detector with
// stretched per-channel pulses, a global OR and sticky event flags.
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous, active-high reset
//   a       in   [WIDTH]    raw asynchronous channel inputs
//   mode    in   [2*WIDTH]  edge mode, channel i at [2i+1:2i]
//                           (00 any, 01 rise, 10 fall, 11 disabled)
//   clr     in   [WIDTH]    per-channel sticky clear strobes
//   pulse   out  [WIDTH]    per-channel qualified event pulses
//   any     out             OR of pulse, registered in the same cycle as pulse
//   sticky  out  [WIDTH]    per-channel latched event flags
// -----------------------------------------------------------------------------
module edge_detect_n
  import edge_detect_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int STRETCH       = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  output logic [WIDTH-1:0]   pulse,
  output logic               any,
  output logic [WIDTH-1:0]   sticky
);

  logic [WIDTH-1:0] pulse_next;
  logic             any_q, any_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    edge_mode_t mode_ch;

    assign mode_ch = edge_mode_t'(mode[2*i +: 2]);

    edge_detect_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .STRETCH      (STRETCH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .a         (a[i]),
      .mode      (mode_ch),
      .clr       (clr[i]),
      .pulse     (pulse[i]),
      .pulse_next(pulse_next[i]),
      .sticky    (sticky[i])
    );
  end

  // Built from the channels' next-state pulses so 'any' rises and falls on
  // the same edge as the pulses it summarises.
  always_comb begin
    any_d = |pulse_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      any_q <= 1'b0;
    end else begin
      any_q <= any_d;
    end
  end

  assign any = any_q;

endmodule

// File: tb/tb_edge_detect_n.sv
// -----------------------------------------------------------------------------
// tb_edge_detect_n
//
// Two instances: dut0 uses the default parameters (STABLE_CYCLES=4,
// STRETCH=1); dut1 uses STABLE_CYCLES=1, STRETCH=3 so that retriggering a
// stretched pulse on one channel is reachable. A reference model driven from
// the input history predicts pulse/any/sticky for both.
// -----------------------------------------------------------------------------
module tb_edge_detect_n;

  localparam int W    = 8;
  localparam int SS   = 2;
  localparam int ST0  = 4;
  localparam int STR0 = 1;
  localparam int ST1  = 1;
  localparam int STR1 = 3;
  localparam int LOGN = 8192;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   a0, clr0, pulse0, sticky0;
  logic [2*W-1:0] mode0;
  logic           any0;
  logic [W-1:0]   a1, clr1, pulse1, sticky1;
  logic [2*W-1:0] mode1;
  logic           any1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  edge_detect_n #(
    .WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(ST0), .STRETCH(STR0)
  ) dut0 (
    .clk(clk), .rst(rst), .a(a0), .mode(mode0), .clr(clr0),
    .pulse(pulse0), .any(any0), .sticky(sticky0)
  );

  edge_detect_n #(
    .WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(ST1), .STRETCH(STR1)
  ) dut1 (
    .clk(clk), .rst(rst), .a(a1), .mode(mode1), .clr(clr1),
    .pulse(pulse1), .any(any1), .sticky(sticky1)
  );

  // ---------------------------------------------------------------------------
  // Reference model. Edge count m_n restarts at 0 on every reset edge. The
  // synchronised value seen at edge n is the raw input recorded SS edges
  // earlier (or the reset value). A transition is accepted when the last
  // STABLE samples all differ from the accepted level. A pulse is high at
  // every edge up to (event edge + STRETCH - 1).
  // ---------------------------------------------------------------------------
  logic [W-1:0] a_log   [2][LOGN];
  logic [W-1:0] rst_val [2];
  logic [W-1:0] lvl     [2];
  logic [W-1:0] exp_pulse  [2];
  logic [W-1:0] exp_sticky [2];
  logic         exp_any [2];
  logic [31:0]  hist [2][W];
  int           nval [2][W];
  int           pend [2][W];
  int           m_n  [2];

  task automatic model_step();
    logic [W-1:0]   av, cv, sv;
    logic [2*W-1:0] mv;
    logic [1:0]     md;
    logic [31:0]    mask;
    logic           acc, ev;
    int             stc, strc;
    for (int k = 0; k < 2; k++) begin
      av   = (k == 0) ? a0 : a1;
      cv   = (k == 0) ? clr0 : clr1;
      mv   = (k == 0) ? mode0 : mode1;
      stc  = (k == 0) ? ST0 : ST1;
      strc = (k == 0) ? STR0 : STR1;
      if (rst) begin
        rst_val[k]    = av;
        lvl[k]        = av;
        m_n[k]        = 0;
        exp_pulse[k]  = '0;
        exp_sticky[k] = '0;
        exp_any[k]    = 1'b0;
        for (int i = 0; i < W; i++) begin
          hist[k][i] = '0;
          nval[k][i] = 0;
          pend[k][i] = -1;
        end
      end else begin
        m_n[k] = m_n[k] + 1;
        if (m_n[k] < LOGN) a_log[k][m_n[k]] = av;
        sv = (m_n[k] - SS >= 1) ? a_log[k][m_n[k] - SS] : rst_val[k];
        mask = (32'd1 << stc) - 32'd1;
        for (int i = 0; i < W; i++) begin
          hist[k][i] = {hist[k][i][30:0], sv[i]};
          if (nval[k][i] < 32) nval[k][i] = nval[k][i] + 1;
          acc = (nval[k][i] >= stc) &&
                ((hist[k][i] & mask) == (lvl[k][i] ? 32'd0 : mask));
          if (acc) lvl[k][i] = ~lvl[k][i];
          md = mv[2*i +: 2];
          ev = acc && ((md == 2'b00) || (md == 2'b01 && lvl[k][i]) ||
                       (md == 2'b10 && !lvl[k][i]));
          if (ev) pend[k][i] = m_n[k] + strc - 1;
          exp_pulse[k][i] = (m_n[k] <= pend[k][i]);
          if (ev)         exp_sticky[k][i] = 1'b1;
          else if (cv[i]) exp_sticky[k][i] = 1'b0;
        end
        exp_any[k] = |exp_pulse[k];
      end
    end
  endtask

  // One clock: the model consumes the inputs the DUT sampled, and outputs are
  // read 1 time unit after the edge. Inputs are only changed after this.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset(input logic [W-1:0] v0, input logic [W-1:0] v1);
    a0 = v0; a1 = v1; clr0 = '0; clr1 = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    mode0 = '0; mode1 = '0;
    apply_reset(8'hA5, 8'hA5);
    for (int t = 0; t < 20; t++) begin
      tick();
      checks++;
      if (pulse0 !== 8'h00 || any0 !== 1'b0 || sticky0 !== 8'h00) begin
        failures++;
        $display("FAIL reset_quiet0 t=%0d: got pulse=%h any=%b sticky=%h expected 00/0/00",
                 t, pulse0, any0, sticky0);
      end
      checks++;
      if (pulse1 !== 8'h00 || any1 !== 1'b0 || sticky1 !== 8'h00) begin
        failures++;
        $display("FAIL reset_quiet1 t=%0d: got pulse=%h any=%b sticky=%h expected 00/0/00",
                 t, pulse1, any1, sticky1);
      end
    end
  endtask

  task automatic test_single_edge();
    logic exp;
    mode0 = '0; mode1 = '0;
    apply_reset('0, '0);
    a0[0] = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      exp = (t == 6);
      checks++;
      if (pulse0 !== {7'd0, exp} || any0 !== exp) begin
        failures++;
        $display("FAIL single_edge t=%0d: got pulse=%h any=%b expected pulse=%h any=%b",
                 t, pulse0, any0, {7'd0, exp}, exp);
      end
    end
    checks++;
    if (sticky0 !== 8'h01) begin
      failures++;
      $display("FAIL single_edge_sticky: got %h expected 01", sticky0);
    end
  endtask

  task automatic test_debounce();
    int pulses;
    int at;
    mode0 = '0; mode1 = '0;
    apply_reset('0, '0);
    // Three-cycle glitch: discarded.
    a0[1] = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      if (t == 4) a0[1] = 1'b0;
      tick();
      checks++;
      if (pulse0[1] !== 1'b0 || sticky0[1] !== 1'b0) begin
        failures++;
        $display("FAIL debounce_glitch t=%0d: got pulse=%b sticky=%b expected 0/0",
                 t, pulse0[1], sticky0[1]);
      end
    end
    // Held high: exactly one event.
    a0[1] = 1'b1;
    pulses = 0;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (pulse0[1] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL debounce_held: got %0d pulses expected 1", pulses);
    end
    // Bounce 0,0,1,0... : filter restarts, event 5 edges after the settle.
    pulses = 0; at = -1;
    for (int t = 1; t <= 16; t++) begin
      if (t == 1) a0[1] = 1'b0;
      if (t == 3) a0[1] = 1'b1;
      if (t == 4) a0[1] = 1'b0;
      tick();
      if (pulse0[1] === 1'b1) begin pulses++; at = t; end
      checks++;
      if (pulse0 !== exp_pulse[0]) begin
        failures++;
        $display("FAIL debounce_model t=%0d: got %h expected %h", t, pulse0, exp_pulse[0]);
      end
    end
    checks++;
    if (pulses != 1 || at != 9) begin
      failures++;
      $display("FAIL debounce_bounce: got %0d pulses at t=%0d expected 1 at t=9", pulses, at);
    end
  endtask

  task automatic test_edge_modes();
    int c2, c3, c4;
    logic v;
    mode0 = '0; mode1 = '0;
    mode0[5:4] = 2'b01;
    mode0[7:6] = 2'b10;
    mode0[9:8] = 2'b11;
    apply_reset('0, '0);
    c2 = 0; c3 = 0; c4 = 0;
    for (int t = 0; t < 66; t++) begin
      v = (t < 60) && ((t % 20) < 10);
      a0[4:2] = {v, v, v};
      tick();
      if (pulse0[2] === 1'b1) c2++;
      if (pulse0[3] === 1'b1) c3++;
      if (pulse0[4] === 1'b1) c4++;
      checks++;
      if (pulse0 !== exp_pulse[0] || any0 !== exp_any[0] || sticky0 !== exp_sticky[0]) begin
        failures++;
        $display("FAIL edge_modes_model t=%0d: got %h/%b/%h expected %h/%b/%h",
                 t, pulse0, any0, sticky0, exp_pulse[0], exp_any[0], exp_sticky[0]);
      end
    end
    checks++;
    if (c2 != 3 || c3 != 3 || c4 != 0) begin
      failures++;
      $display("FAIL edge_modes_counts: got rise=%0d fall=%0d off=%0d expected 3/3/0", c2, c3, c4);
    end
    // Re-enable ch4 while its level is stable: no stale event.
    mode0[9:8] = 2'b00;
    for (int t = 0; t < 10; t++) begin
      tick();
      checks++;
      if (pulse0[4] !== 1'b0 || sticky0[4] !== 1'b0) begin
        failures++;
        $display("FAIL edge_modes_reenable t=%0d: got pulse=%b sticky=%b expected 0/0",
                 t, pulse0[4], sticky0[4]);
      end
    end
  endtask

  task automatic test_stretch();
    logic exp;
    mode0 = '0; mode1 = '0;
    apply_reset('0, '0);
    // Two events two edges apart: one continuous 5-cycle pulse.
    a1[0] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      if (t == 3) a1[0] = 1'b0;
      tick();
      exp = (t >= 3) && (t <= 7);
      checks++;
      if (pulse1[0] !== exp || any1 !== exp) begin
        failures++;
        $display("FAIL stretch_retrigger t=%0d: got pulse=%b any=%b expected %b",
                 t, pulse1[0], any1, exp);
      end
    end
    // Isolated event: 3 cycles high.
    a1[0] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp = (t >= 3) && (t <= 5);
      checks++;
      if (pulse1[0] !== exp || pulse1 !== exp_pulse[1]) begin
        failures++;
        $display("FAIL stretch_single t=%0d: got pulse=%h expected %h (bit0 %b)",
                 t, pulse1, exp_pulse[1], exp);
      end
    end
  endtask

  task automatic test_sticky_clr();
    mode0 = '0; mode1 = '0;
    apply_reset('0, '0);
    a0[5] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      clr0 = (t == 6) ? 8'h20 : 8'h00;
      tick();
      checks++;
      if (sticky0[5] !== (t >= 6) || pulse0[5] !== (t == 6)) begin
        failures++;
        $display("FAIL sticky_set_wins t=%0d: got sticky=%b pulse=%b expected %b/%b",
                 t, sticky0[5], pulse0[5], (t >= 6), (t == 6));
      end
    end
    clr0 = 8'h20;
    tick();
    clr0 = 8'h00;
    checks++;
    if (sticky0[5] !== 1'b0 || sticky0 !== exp_sticky[0]) begin
      failures++;
      $display("FAIL sticky_clear: got %h expected %h", sticky0, exp_sticky[0]);
    end
  endtask

  task automatic test_rst_mid();
    // dut1 ch0 is high after test_stretch's reset? Start from a clean reset.
    mode0 = '0; mode1 = '0;
    apply_reset('0, '0);
    a1[0] = 1'b1;
    a0[6] = 1'b1;
    for (int t = 1; t <= 3; t++) tick();
    checks++;
    if (pulse1[0] !== 1'b1 || sticky1[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: got pulse=%b sticky=%b expected 1/1", pulse1[0], sticky1[0]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (pulse1 !== 8'h00 || any1 !== 1'b0 || sticky1 !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid: got pulse=%h any=%b sticky=%h expected 00/0/00",
               pulse1, any1, sticky1);
    end
    rst = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++;
      if (pulse0 !== 8'h00 || pulse1 !== 8'h00) begin
        failures++;
        $display("FAIL rst_mid_after t=%0d: got %h/%h expected 00/00", t, pulse0, pulse1);
      end
    end
  endtask

  task automatic test_random();
    mode0 = W'(0) == 0 ? 16'h0000 : 16'h0000;
    mode1 = 16'h0000;
    apply_reset(8'($urandom()), 8'($urandom()));
    for (int t = 0; t < 1500; t++) begin
      if (t % 50 == 0) begin
        mode0 = 16'($urandom());
        mode1 = 16'($urandom());
      end
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 7) == 0) a0[i] = ~a0[i];
        if ($urandom_range(0, 5) == 0) a1[i] = ~a1[i];
      end
      clr0 = 8'($urandom() & $urandom() & $urandom() & $urandom());
      clr1 = 8'($urandom() & $urandom() & $urandom() & $urandom());
      rst  = ($urandom_range(0, 399) == 0);
      tick();
      checks++;
      if (pulse0 !== exp_pulse[0] || any0 !== exp_any[0] || sticky0 !== exp_sticky[0]) begin
        failures++;
        $display("FAIL random0 t=%0d: got %h/%b/%h expected %h/%b/%h",
                 t, pulse0, any0, sticky0, exp_pulse[0], exp_any[0], exp_sticky[0]);
      end
      checks++;
      if (pulse1 !== exp_pulse[1] || any1 !== exp_any[1] || sticky1 !== exp_sticky[1]) begin
        failures++;
        $display("FAIL random1 t=%0d: got %h/%b/%h expected %h/%b/%h",
                 t, pulse1, any1, sticky1, exp_pulse[1], exp_any[1], exp_sticky[1]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a0 = '0; a1 = '0; clr0 = '0; clr1 = '0; mode0 = '0; mode1 = '0;
    test_reset();
    test_single_edge();
    test_debounce();
    test_edge_modes();
    test_stretch();
    test_sticky_clr();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
